// File: rtl/axi_burst_reader.sv
// axi_burst_reader
//   Issues one AXI4 INCR read burst per accepted command and forwards the
//   returned beats onto a ready/valid stream with no added latency. Only one
//   burst is outstanding at a time. Protocol or response problems seen on the
//   R channel are collected into a sticky error flag that is reported with the
//   one-cycle completion pulse.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cmd_valid/ready          command handshake
//   cmd_addr/len/id          start byte address, beats minus one, AXI ID
//   m_axi_ar*                AXI4 read address channel (master side)
//   m_axi_r*                 AXI4 read data channel (master side)
//   out_data/last/valid      read data stream, out_ready is its backpressure
//   done                     one-cycle pulse after the final beat
//   err                      sticky burst error, cleared by the next command
module axi_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [ID_WIDTH-1:0]   cmd_id,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,

    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,

    output logic                  done,
    output logic                  err
);

    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            cnt_q;
    logic                  arvalid_q;
    logic                  done_q;
    logic                  err_q;

    logic in_data;
    logic cnt_zero;
    logic r_hs;
    logic beat_err;

    assign in_data  = (state_q == DATA) && !rst;
    assign cnt_zero = (cnt_q == '0);
    assign r_hs     = in_data && m_axi_rvalid && out_ready;

    // The burst length comes from the command, not from the slave: rlast is
    // only checked against the local beat count, never used to end the burst.
    assign beat_err = (m_axi_rresp != 2'b00) ||
                      (m_axi_rid != id_q) ||
                      (m_axi_rlast != cnt_zero);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        len_q     <= cmd_len;
                        id_q      <= cmd_id;
                        err_q     <= 1'b0;
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        cnt_q     <= len_q;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        if (beat_err) begin
                            err_q <= 1'b1;
                        end
                        if (cnt_zero) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake and status outputs are masked while rst is high so that an
    // in-flight burst goes quiet in the reset cycle itself, not one later.
    assign cmd_ready     = (state_q == IDLE) && !rst;

    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = ARSIZE;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q && !rst;

    assign m_axi_rready  = in_data && out_ready;
    assign out_valid     = in_data && m_axi_rvalid;
    assign out_data      = m_axi_rdata;
    assign out_last      = in_data && cnt_zero;

    assign done          = done_q && !rst;
    assign err           = err_q && !rst;

endmodule
